// File: rtl/hazard_scoreboard.sv
// Interlock controller for the 5-stage core: tracks in-flight load and long-op
// writes, stalls dependents in D, and squashes D/E on a taken branch in E.
module hazard_scoreboard_entry #(
  parameter int LOAD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic       ld,
  input  logic       lng,
  input  logic       done,
  output logic [1:0] cnt,
  output logic       lbusy
);
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= 2'd0;
      lbusy <= 1'b0;
    end else begin
      if (wr)                cnt <= ld ? 2'(LOAD_LAT) : 2'd0;
      else if (cnt != 2'd0)  cnt <= cnt - 2'd1;
      // An issue can never target a busy register (WAW blocks it), so issue wins.
      if (wr)        lbusy <= lng & ~ld;
      else if (done) lbusy <= 1'b0;
    end
  end
endmodule

module hazard_scoreboard #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteD,
  input  logic             ResultSrcD,
  input  logic             LongOpD,
  input  logic [4:0]       RD_D,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic             UsesRs1D,
  input  logic             UsesRs2D,
  input  logic             PCSrcE,
  input  logic             LongDoneW,
  input  logic [4:0]       LongRdW,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] stall_count
);
  logic [31:1][1:0] cnt;
  logic [31:0]      busy;
  logic [31:0]      lpend;
  logic             src_hz, waw_hz, hz, issue;

  // Entry 0 is x0: never busy, never pending.
  assign busy[0]  = 1'b0;
  assign lpend[0] = 1'b0;

  generate
    for (genvar i = 1; i < 32; i++) begin : g_reg
      hazard_scoreboard_entry #(.LOAD_LAT(LOAD_LAT)) u_entry (
        .clk   (clk),
        .rst   (rst),
        .wr    (issue && (RD_D == 5'(i))),
        .ld    (ResultSrcD),
        .lng   (LongOpD),
        .done  (LongDoneW && (LongRdW == 5'(i))),
        .cnt   (cnt[i]),
        .lbusy (lpend[i])
      );
      assign busy[i] = (cnt[i] != 2'd0) | lpend[i];
    end
  endgenerate

  assign src_hz = (UsesRs1D & busy[Rs1_D]) | (UsesRs2D & busy[Rs2_D]);
  assign waw_hz = RegWriteD & lpend[RD_D];
  assign hz     = (src_hz | waw_hz) & ~PCSrcE;
  assign issue  = ~hz & ~PCSrcE & RegWriteD & (RD_D != 5'd0);

  assign StallF = rst & hz;
  assign StallD = rst & hz;
  assign FlushD = rst & PCSrcE;
  assign FlushE = rst & (hz | PCSrcE);

  always_ff @(posedge clk) begin
    if (!rst)                        stall_count <= '0;
    else if (StallD && !(&stall_count)) stall_count <= stall_count + 1'b1;
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: main instance LOAD_LAT=1/CNT_W=16,
// second instance LOAD_LAT=2/CNT_W=4 sharing the same stimulus.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst, rw, ld, lng, u1, u2, pcs, ldone;
  logic [4:0] rd, rs1, rs2, lrd;
  logic sf1, sd1, fd1, fe1, sf2, sd2, fd2, fe2;
  logic [15:0] sc1;
  logic [3:0]  sc2;
  logic [3:0]  ctl1, ctl2;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign ctl1 = {sf1, sd1, fd1, fe1};
  assign ctl2 = {sf2, sd2, fd2, fe2};

  hazard_scoreboard #(.LOAD_LAT(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .RegWriteD(rw), .ResultSrcD(ld), .LongOpD(lng),
    .RD_D(rd), .Rs1_D(rs1), .Rs2_D(rs2), .UsesRs1D(u1), .UsesRs2D(u2),
    .PCSrcE(pcs), .LongDoneW(ldone), .LongRdW(lrd),
    .StallF(sf1), .StallD(sd1), .FlushD(fd1), .FlushE(fe1), .stall_count(sc1));

  hazard_scoreboard #(.LOAD_LAT(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .RegWriteD(rw), .ResultSrcD(ld), .LongOpD(lng),
    .RD_D(rd), .Rs1_D(rs1), .Rs2_D(rs2), .UsesRs1D(u1), .UsesRs2D(u2),
    .PCSrcE(pcs), .LongDoneW(ldone), .LongRdW(lrd),
    .StallF(sf2), .StallD(sd2), .FlushD(fd2), .FlushE(fe2), .stall_count(sc2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic d_set(input logic rw_i, ld_i, lng_i, input logic [4:0] rd_i, rs1_i, rs2_i,
                       input logic u1_i, u2_i);
    rw = rw_i; ld = ld_i; lng = lng_i; rd = rd_i;
    rs1 = rs1_i; rs2 = rs2_i; u1 = u1_i; u2 = u2_i;
  endtask

  task automatic idle;
    d_set(0, 0, 0, 0, 0, 0, 0, 0);
    pcs = 0; ldone = 0; lrd = 0;
  endtask

  task automatic do_reset;
    rst = 0; idle(); tick(); rst = 1;
  endtask

  task automatic test_reset;
    rst = 0; idle(); pcs = 1; d_set(1, 1, 0, 5'd3, 5'd3, 5'd3, 1, 1);
    tick(); #4;
    n_cmp++; if (ctl1 !== 4'b0000) begin n_fail++; $display("FAIL reset_ctl1: got %b want 0000", ctl1); end
    n_cmp++; if (ctl2 !== 4'b0000) begin n_fail++; $display("FAIL reset_ctl2: got %b want 0000", ctl2); end
    n_cmp++; if (sc1 !== 16'd0) begin n_fail++; $display("FAIL reset_cnt1: got %0d want 0", sc1); end
    n_cmp++; if (sc2 !== 4'd0) begin n_fail++; $display("FAIL reset_cnt2: got %0d want 0", sc2); end
    rst = 1; idle(); tick();
  endtask

  task automatic test_load_use;
    do_reset();
    d_set(1, 1, 0, 5'd5, 5'd0, 5'd0, 0, 0); #4;  // lw x5
    n_cmp++; if (ctl1 !== 4'b0000) begin n_fail++; $display("FAIL lu_issue: got %b want 0000", ctl1); end
    tick(); d_set(1, 0, 0, 5'd6, 5'd5, 5'd1, 1, 1); #4;  // add x6,x5,x1
    n_cmp++; if (ctl1 !== 4'b1101) begin n_fail++; $display("FAIL lu_stall: got %b want 1101", ctl1); end
    tick(); #4;
    n_cmp++; if (ctl1 !== 4'b0000) begin n_fail++; $display("FAIL lu_release: got %b want 0000", ctl1); end
    idle(); tick(); #4;
    n_cmp++; if (sc1 !== 16'd1) begin n_fail++; $display("FAIL lu_count: got %0d want 1", sc1); end
  endtask

  task automatic test_load_spacing;
    do_reset();
    d_set(1, 1, 0, 5'd5, 5'd0, 5'd0, 0, 0); tick();
    d_set(1, 0, 0, 5'd7, 5'd1, 5'd0, 1, 0); #4;  // independent
    n_cmp++; if (ctl1 !== 4'b0000) begin n_fail++; $display("FAIL sp_indep: got %b want 0000", ctl1); end
    tick(); d_set(1, 0, 0, 5'd6, 5'd5, 5'd0, 1, 0); #4;
    n_cmp++; if (ctl1 !== 4'b0000) begin n_fail++; $display("FAIL sp_lat1_gap: got %b want 0000", ctl1); end
    n_cmp++; if (ctl2 !== 4'b1101) begin n_fail++; $display("FAIL sp_lat2_gap: got %b want 1101", ctl2); end
    tick(); #4;
    n_cmp++; if (ctl2 !== 4'b0000) begin n_fail++; $display("FAIL sp_lat2_release: got %b want 0000", ctl2); end
    // LOAD_LAT=2: dependent right after the load stalls two cycles
    do_reset();
    d_set(1, 1, 0, 5'd5, 5'd0, 5'd0, 0, 0); tick();
    d_set(1, 0, 0, 5'd7, 5'd5, 5'd0, 1, 0); #4;
    n_cmp++; if (ctl2 !== 4'b1101) begin n_fail++; $display("FAIL l2_stall1: got %b want 1101", ctl2); end
    tick(); #4;
    n_cmp++; if (ctl2 !== 4'b1101) begin n_fail++; $display("FAIL l2_stall2: got %b want 1101", ctl2); end
    n_cmp++; if (ctl1 !== 4'b0000) begin n_fail++; $display("FAIL l1_stall2: got %b want 0000", ctl1); end
    tick(); #4;
    n_cmp++; if (ctl2 !== 4'b0000) begin n_fail++; $display("FAIL l2_release: got %b want 0000", ctl2); end
    n_cmp++; if (sc2 !== 4'd2) begin n_fail++; $display("FAIL l2_count: got %0d want 2", sc2); end
  endtask

  task automatic test_long;
    do_reset();
    d_set(1, 0, 1, 5'd9, 5'd0, 5'd0, 0, 0); tick();  // div x9
    d_set(1, 0, 0, 5'd9, 5'd1, 5'd0, 1, 0); #4;     // WAW on x9
    n_cmp++; if (ctl1 !== 4'b1101) begin n_fail++; $display("FAIL long_waw: got %b want 1101", ctl1); end
    tick(); d_set(1, 0, 0, 5'd3, 5'd9, 5'd2, 1, 1);  // sub x3,x9,x2
    for (int i = 0; i < 4; i++) begin
      #4;
      n_cmp++; if (ctl1 !== 4'b1101) begin n_fail++; $display("FAIL long_hold%0d: got %b want 1101", i, ctl1); end
      tick();
    end
    ldone = 1; lrd = 5'd8; #4;
    n_cmp++; if (ctl1 !== 4'b1101) begin n_fail++; $display("FAIL long_pulse8: got %b want 1101", ctl1); end
    tick(); ldone = 0; #4;
    n_cmp++; if (ctl1 !== 4'b1101) begin n_fail++; $display("FAIL long_after8: got %b want 1101", ctl1); end
    tick(); ldone = 1; lrd = 5'd9; #4;
    n_cmp++; if (ctl1 !== 4'b1101) begin n_fail++; $display("FAIL long_pulse9: got %b want 1101", ctl1); end
    tick(); ldone = 0; #4;
    n_cmp++; if (ctl1 !== 4'b0000) begin n_fail++; $display("FAIL long_release: got %b want 0000", ctl1); end
    n_cmp++; if (sc1 !== 16'd8) begin n_fail++; $display("FAIL long_count: got %0d want 8", sc1); end
  endtask

  task automatic test_branch;
    do_reset();
    d_set(1, 1, 0, 5'd5, 5'd0, 5'd0, 0, 0); tick();
    pcs = 1; d_set(1, 0, 1, 5'd6, 5'd5, 5'd0, 1, 0); #4;  // div x6,x5 squashed
    n_cmp++; if (ctl1 !== 4'b0011) begin n_fail++; $display("FAIL br_prio: got %b want 0011", ctl1); end
    tick(); d_set(1, 1, 0, 5'd12, 5'd0, 5'd0, 0, 0); #4;  // lw x12 squashed
    n_cmp++; if (ctl1 !== 4'b0011) begin n_fail++; $display("FAIL br_flush: got %b want 0011", ctl1); end
    n_cmp++; if (sc1 !== 16'd0) begin n_fail++; $display("FAIL br_count: got %0d want 0", sc1); end
    tick(); pcs = 0; d_set(1, 0, 0, 5'd7, 5'd6, 5'd12, 1, 1); #4;
    n_cmp++; if (ctl1 !== 4'b0000) begin n_fail++; $display("FAIL br_nostate: got %b want 0000", ctl1); end
    tick();
  endtask

  task automatic test_x0;
    do_reset();
    d_set(1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0); tick();  // lw x0
    d_set(1, 0, 0, 5'd1, 5'd0, 5'd0, 1, 1); #4;
    n_cmp++; if (ctl1 !== 4'b0000) begin n_fail++; $display("FAIL x0_load: got %b want 0000", ctl1); end
    tick(); d_set(1, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0); tick();  // div x0
    d_set(1, 0, 0, 5'd0, 5'd0, 5'd0, 1, 1); #4;
    n_cmp++; if (ctl1 !== 4'b0000) begin n_fail++; $display("FAIL x0_long: got %b want 0000", ctl1); end
    tick(); d_set(1, 1, 0, 5'd5, 5'd0, 5'd0, 0, 0); tick();
    d_set(1, 0, 0, 5'd6, 5'd5, 5'd0, 0, 1); #4;  // Rs1 matches but unused
    n_cmp++; if (ctl1 !== 4'b0000) begin n_fail++; $display("FAIL x0_unused: got %b want 0000", ctl1); end
    tick();
  endtask

  task automatic test_reset_mid;
    do_reset();
    d_set(1, 0, 1, 5'd4, 5'd0, 5'd0, 0, 0); tick();  // div x4
    d_set(1, 0, 0, 5'd5, 5'd4, 5'd0, 1, 0); #4;
    n_cmp++; if (ctl1 !== 4'b1101) begin n_fail++; $display("FAIL rm_pending: got %b want 1101", ctl1); end
    rst = 0; idle(); tick(); rst = 1;
    d_set(1, 0, 0, 5'd5, 5'd4, 5'd0, 1, 0); #4;
    n_cmp++; if (ctl1 !== 4'b0000) begin n_fail++; $display("FAIL rm_cleared: got %b want 0000", ctl1); end
    tick(); #4;
    n_cmp++; if (sc1 !== 16'd0) begin n_fail++; $display("FAIL rm_count: got %0d want 0", sc1); end
  endtask

  task automatic test_saturate;
    do_reset();
    d_set(1, 0, 1, 5'd4, 5'd0, 5'd0, 0, 0); tick();
    d_set(1, 0, 0, 5'd5, 5'd4, 5'd0, 1, 0);
    repeat (14) tick();
    #4;
    n_cmp++; if (sc2 !== 4'd14) begin n_fail++; $display("FAIL sat_pre: got %0d want 14", sc2); end
    repeat (5) tick();
    #4;
    n_cmp++; if (sc2 !== 4'hF) begin n_fail++; $display("FAIL sat_hold: got %0d want 15", sc2); end
    n_cmp++; if (sc1 !== 16'd19) begin n_fail++; $display("FAIL sat_wide: got %0d want 19", sc1); end
    n_cmp++; if (ctl2 !== 4'b1101) begin n_fail++; $display("FAIL sat_ctl: got %b want 1101", ctl2); end
    idle(); tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_load_spacing();
    test_long();
    test_branch();
    test_x0();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
